// File: rtl/sched_pkg.sv
// Shared types and constants for the dual-issue scheduler slice.
package sched_pkg;

  localparam int unsigned SCHED_REG_W = 4;
  localparam int unsigned SCHED_OP_W  = 8;

  // All-ones register specifier means "no register".
  localparam logic [SCHED_REG_W-1:0] REG_NONE = '1;

  typedef struct packed {
    logic [SCHED_REG_W-1:0] des;
    logic [SCHED_REG_W-1:0] s1;
    logic [SCHED_REG_W-1:0] s2;
    logic [SCHED_OP_W-1:0]  op;
  } instr_t;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    HOLD_BOTH  = 2'd1,
    HOLD_YOUNG = 2'd2
  } sched_state_t;

  function automatic logic reg_used(input logic [SCHED_REG_W-1:0] r);
    return r != REG_NONE;
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_scoreboard.sv
// Busy-bit array of in-flight destinations with two set ports, one clear
// port and a three-register "clear" lookup for each slot.
module sched_scoreboard
  import sched_pkg::*;
#(
  parameter int unsigned REG_W = SCHED_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set0_i,
  input  logic [REG_W-1:0] set0_des_i,
  input  logic             set1_i,
  input  logic [REG_W-1:0] set1_des_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_des_i,
  input  logic [REG_W-1:0] l0_des_i,
  input  logic [REG_W-1:0] l0_s1_i,
  input  logic [REG_W-1:0] l0_s2_i,
  input  logic [REG_W-1:0] l1_des_i,
  input  logic [REG_W-1:0] l1_s1_i,
  input  logic [REG_W-1:0] l1_s2_i,
  output logic             clear0_o,
  output logic             clear1_o
);

  localparam int unsigned NREG = 1 << REG_W;

  logic [NREG-1:0] busy_q, busy_d;

  function automatic logic hit(input logic [NREG-1:0] b, input logic [REG_W-1:0] r);
    return reg_used(r) && b[r];
  endfunction

  // Lookups use registered bits only: a writeback shows up a cycle later.
  always_comb begin
    clear0_o = !(hit(busy_q, l0_des_i) || hit(busy_q, l0_s1_i) || hit(busy_q, l0_s2_i));
    clear1_o = !(hit(busy_q, l1_des_i) || hit(busy_q, l1_s1_i) || hit(busy_q, l1_s2_i));
  end

  // Clear applied first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i && reg_used(clr_des_i)) busy_d[clr_des_i] = 1'b0;
    if (set0_i && reg_used(set0_des_i)) busy_d[set0_des_i] = 1'b1;
    if (set1_i && reg_used(set1_des_i)) busy_d[set1_des_i] = 1'b1;
  end

  // Busy-bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/raw_war_checker_part.sv
// Intra-pair RAW/WAR detector: younger slot reads the older dest, or
// writes a register the older slot still has to read.
module raw_war_checker_part
  import sched_pkg::*;
#(
  parameter int unsigned REG_W = SCHED_REG_W
) (
  input  logic             pair_i,
  input  logic [REG_W-1:0] des0_i,
  input  logic [REG_W-1:0] s01_i,
  input  logic [REG_W-1:0] s02_i,
  input  logic [REG_W-1:0] des1_i,
  input  logic [REG_W-1:0] s11_i,
  input  logic [REG_W-1:0] s12_i,
  output logic             hazard_o
);

  logic raw, war;

  // REG_NONE never creates a dependency in either direction.
  always_comb begin
    raw      = reg_used(des0_i) && ((s11_i == des0_i) || (s12_i == des0_i));
    war      = reg_used(des1_i) && ((des1_i == s01_i) || (des1_i == s02_i));
    hazard_o = pair_i && (raw || war);
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: holds one in-order pair, issues both lanes when
// independent, otherwise one per cycle, gated by the busy-bit scoreboard.
module dual_issue_scheduler
  import sched_pkg::*;
#(
  // Widths must match the package struct; defaults track it.
  parameter int unsigned REG_W = SCHED_REG_W,
  parameter int unsigned OP_W  = SCHED_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_pair,
  input  logic [REG_W-1:0] in_des0,
  input  logic [REG_W-1:0] in_s01,
  input  logic [REG_W-1:0] in_s02,
  input  logic [REG_W-1:0] in_des1,
  input  logic [REG_W-1:0] in_s11,
  input  logic [REG_W-1:0] in_s12,
  input  logic [OP_W-1:0]  in_op0,
  input  logic [OP_W-1:0]  in_op1,
  input  logic             iss_ready,
  output logic             iss0_valid,
  output logic [REG_W-1:0] iss0_des,
  output logic [REG_W-1:0] iss0_s1,
  output logic [REG_W-1:0] iss0_s2,
  output logic [OP_W-1:0]  iss0_op,
  output logic             iss1_valid,
  output logic [REG_W-1:0] iss1_des,
  output logic [REG_W-1:0] iss1_s1,
  output logic [REG_W-1:0] iss1_s2,
  output logic [OP_W-1:0]  iss1_op,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_des
);

  sched_state_t state_q, state_d;
  instr_t       slot0_q, slot1_q;
  logic         pair_q;
  logic         iss0_valid_q, iss1_valid_q;
  instr_t       iss0_q, iss1_q;

  logic         free, clear0, clear1, raw_war_hz, pair_hz, accept;
  logic         lane0_v, lane1_v;
  instr_t       lane0_d, lane1_d;

  raw_war_checker_part #(.REG_W(REG_W)) u_raw_war (
    .pair_i   (pair_q),
    .des0_i   (slot0_q.des),
    .s01_i    (slot0_q.s1),
    .s02_i    (slot0_q.s2),
    .des1_i   (slot1_q.des),
    .s11_i    (slot1_q.s1),
    .s12_i    (slot1_q.s2),
    .hazard_o (raw_war_hz)
  );

  sched_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set0_i     (free && lane0_v),
    .set0_des_i (lane0_d.des),
    .set1_i     (free && lane1_v),
    .set1_des_i (lane1_d.des),
    .clr_i      (wb_valid),
    .clr_des_i  (wb_des),
    .l0_des_i   (slot0_q.des),
    .l0_s1_i    (slot0_q.s1),
    .l0_s2_i    (slot0_q.s2),
    .l1_des_i   (slot1_q.des),
    .l1_s1_i    (slot1_q.s1),
    .l1_s2_i    (slot1_q.s2),
    .clear0_o   (clear0),
    .clear1_o   (clear1)
  );

  // Issue decision for the current cycle and the resulting hold state.
  always_comb begin
    free    = !iss0_valid_q || iss_ready;
    pair_hz = raw_war_hz || (pair_q && (slot0_q.des == slot1_q.des) && reg_used(slot0_q.des));
    lane0_v = 1'b0;
    lane1_v = 1'b0;
    lane0_d = '0;
    lane1_d = '0;
    state_d = state_q;
    case (state_q)
      HOLD_BOTH: begin
        if (free && clear0) begin
          lane0_v = 1'b1;
          lane0_d = slot0_q;
          if (pair_q && clear1 && !pair_hz) begin
            lane1_v = 1'b1;
            lane1_d = slot1_q;
            state_d = EMPTY;
          end else begin
            state_d = pair_q ? HOLD_YOUNG : EMPTY;
          end
        end
      end
      HOLD_YOUNG: begin
        // The older slot is gone; only the scoreboard gates slot1 now.
        if (free && clear1) begin
          lane0_v = 1'b1;
          lane0_d = slot1_q;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready = rst_n && (state_d == EMPTY);
    accept   = in_valid && in_ready;
  end

  // Hold FSM, bundle latch and registered issue group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      slot0_q      <= '0;
      slot1_q      <= '0;
      pair_q       <= 1'b0;
      iss0_valid_q <= 1'b0;
      iss1_valid_q <= 1'b0;
      iss0_q       <= '0;
      iss1_q       <= '0;
    end else begin
      if (free) begin
        iss0_valid_q <= lane0_v;
        iss1_valid_q <= lane1_v;
        iss0_q       <= lane0_d;
        iss1_q       <= lane1_d;
      end
      if (accept) begin
        state_q <= HOLD_BOTH;
        pair_q  <= in_pair;
        slot0_q <= '{des: in_des0, s1: in_s01, s2: in_s02, op: in_op0};
        slot1_q <= in_pair ? instr_t'{des: in_des1, s1: in_s11, s2: in_s12, op: in_op1} : '0;
      end else begin
        state_q <= state_d;
      end
    end
  end

  always_comb begin
    iss0_valid = iss0_valid_q;
    iss0_des   = iss0_q.des;
    iss0_s1    = iss0_q.s1;
    iss0_s2    = iss0_q.s2;
    iss0_op    = iss0_q.op;
    iss1_valid = iss1_valid_q;
    iss1_des   = iss1_q.des;
    iss1_s1    = iss1_q.s1;
    iss1_s2    = iss1_q.s2;
    iss1_op    = iss1_q.op;
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler with directed bundles.
module tb_dual_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_pair;
  logic [3:0] in_des0, in_s01, in_s02, in_des1, in_s11, in_s12;
  logic [7:0] in_op0, in_op1;
  logic       iss_ready;
  logic       iss0_valid, iss1_valid;
  logic [3:0] iss0_des, iss0_s1, iss0_s2, iss1_des, iss1_s1, iss1_s2;
  logic [7:0] iss0_op, iss1_op;
  logic       wb_valid;
  logic [3:0] wb_des;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.REG_W(4), .OP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pair(in_pair),
    .in_des0(in_des0), .in_s01(in_s01), .in_s02(in_s02),
    .in_des1(in_des1), .in_s11(in_s11), .in_s12(in_s12),
    .in_op0(in_op0), .in_op1(in_op1),
    .iss_ready(iss_ready),
    .iss0_valid(iss0_valid), .iss0_des(iss0_des), .iss0_s1(iss0_s1),
    .iss0_s2(iss0_s2), .iss0_op(iss0_op),
    .iss1_valid(iss1_valid), .iss1_des(iss1_des), .iss1_s1(iss1_s1),
    .iss1_s2(iss1_s2), .iss1_op(iss1_op),
    .wb_valid(wb_valid), .wb_des(wb_des)
  );

  typedef struct packed {
    logic       v1;
    logic [3:0] d0, a0, b0;
    logic [7:0] o0;
    logic [3:0] d1, a1, b1;
    logic [7:0] o1;
  } grp_t;

  grp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic grp_t g1(input logic [3:0] d, a, b, input logic [7:0] o);
    grp_t g;
    g = '0;
    g.d0 = d; g.a0 = a; g.b0 = b; g.o0 = o;
    return g;
  endfunction

  function automatic grp_t g2(input logic [3:0] d0, a0, b0, input logic [7:0] o0,
                              input logic [3:0] d1, a1, b1, input logic [7:0] o1);
    grp_t g;
    g = g1(d0, a0, b0, o0);
    g.v1 = 1'b1;
    g.d1 = d1; g.a1 = a1; g.b1 = b1; g.o1 = o1;
    return g;
  endfunction

  // Monitor: every issue group the execute stage accepts is popped and compared.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && iss0_valid === 1'b1 && iss_ready === 1'b1) begin
      grp_t e, a;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL issue_unexpected: got op0=%0h with no group expected", iss0_op);
      end else begin
        e = exp_q.pop_front();
        a = g1(iss0_des, iss0_s1, iss0_s2, iss0_op);
        a.v1 = iss1_valid;
        if (e.v1) begin
          a.d1 = iss1_des; a.a1 = iss1_s1; a.b1 = iss1_s2; a.o1 = iss1_op;
        end
        if (a !== e) begin
          n_bad++;
          $display("FAIL issue_group: got %h expected %h", a, e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] d0, a0, b0, input logic [7:0] o0, input logic pr,
                      input logic [3:0] d1, a1, b1, input logic [7:0] o1);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_pair = pr;
    in_des0 = d0; in_s01 = a0; in_s02 = b0; in_op0 = o0;
    in_des1 = d1; in_s11 = a1; in_s12 = b1; in_op1 = o1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] d);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_des = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pair = 1'b0; iss_ready = 1'b1;
    in_des0 = '0; in_s01 = '0; in_s02 = '0; in_des1 = '0; in_s11 = '0; in_s12 = '0;
    in_op0 = '0; in_op1 = '0; wb_valid = 1'b0; wb_des = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_iss0_valid", iss0_valid, 0);
    check("rst_iss1_valid", iss1_valid, 0);
    check("rst_iss0_op", iss0_op, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Independent pair: dual issue two cycles after acceptance.
    exp_q.push_back(g2(4'd1, 4'd2, 4'd3, 8'h11, 4'd4, 4'd5, 4'd6, 8'h12));
    send(4'd1, 4'd2, 4'd3, 8'h11, 1'b1, 4'd4, 4'd5, 4'd6, 8'h12);
    @(negedge clk);
    check("lat_n1_valid", iss0_valid, 0);
    @(negedge clk);
    check("lat_n2_valid", iss0_valid, 1);
    wait_drain(10);
    wb(4'd1);
    wb(4'd4);

    // RAW pair: slot1 waits for writeback of r1.
    exp_q.push_back(g1(4'd1, 4'd2, 4'd3, 8'h21));
    exp_q.push_back(g1(4'd5, 4'd1, 4'd6, 8'h22));
    send(4'd1, 4'd2, 4'd3, 8'h21, 1'b1, 4'd5, 4'd1, 4'd6, 8'h22);
    repeat (4) @(negedge clk);
    check("raw_blocked_valid", iss0_valid, 0);
    check("raw_blocked_ready", in_ready, 0);
    wb(4'd1);
    @(negedge clk);
    check("raw_wb_n1", iss0_valid, 0);
    @(negedge clk);
    check("raw_wb_n2", iss0_valid, 1);
    wait_drain(10);
    wb(4'd5);

    // WAW pair: split issue, second waits for r7 writeback.
    exp_q.push_back(g1(4'd7, 4'd2, 4'd3, 8'h31));
    exp_q.push_back(g1(4'd7, 4'd4, 4'd5, 8'h32));
    send(4'd7, 4'd2, 4'd3, 8'h31, 1'b1, 4'd7, 4'd4, 4'd5, 8'h32);
    repeat (4) @(negedge clk);
    check("waw_blocked_valid", iss0_valid, 0);
    check("waw_pending", exp_q.size(), 1);
    wb(4'd7);
    wait_drain(10);
    wb(4'd7);

    // REG_NONE dest against REG_NONE source: no hazard.
    exp_q.push_back(g2(4'hF, 4'd2, 4'd3, 8'h41, 4'd8, 4'hF, 4'd9, 8'h42));
    send(4'hF, 4'd2, 4'd3, 8'h41, 1'b1, 4'd8, 4'hF, 4'd9, 8'h42);
    wait_drain(10);
    wb(4'd8);

    // Back-pressure: stable outputs and in_ready low while a bundle is held.
    @(posedge clk); #1 iss_ready = 1'b0;
    exp_q.push_back(g2(4'd10, 4'd2, 4'd3, 8'h51, 4'd11, 4'd2, 4'd3, 8'h52));
    exp_q.push_back(g2(4'd12, 4'd2, 4'd3, 8'h53, 4'd13, 4'd2, 4'd3, 8'h54));
    exp_q.push_back(g1(4'd14, 4'd2, 4'd3, 8'h55));
    send(4'd10, 4'd2, 4'd3, 8'h51, 1'b1, 4'd11, 4'd2, 4'd3, 8'h52);
    send(4'd12, 4'd2, 4'd3, 8'h53, 1'b1, 4'd13, 4'd2, 4'd3, 8'h54);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_v0", iss0_valid, 1);
      check("stall_v1", iss1_valid, 1);
      check("stall_op0", iss0_op, 8'h51);
      check("stall_op1", iss1_op, 8'h52);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    iss_ready = 1'b1;
    in_valid = 1'b1; in_pair = 1'b0;
    in_des0 = 4'd14; in_s01 = 4'd2; in_s02 = 4'd3; in_op0 = 8'h55;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain(10);

    // Same-cycle set and writeback on r3: set must win.
    exp_q.push_back(g1(4'd3, 4'd2, 4'd5, 8'h61));
    send(4'd3, 4'd2, 4'd5, 8'h61, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
    wb_valid = 1'b1; wb_des = 4'd3;
    @(posedge clk); #1 wb_valid = 1'b0;
    exp_q.push_back(g1(4'd6, 4'd3, 4'd2, 8'h62));
    send(4'd6, 4'd3, 4'd2, 8'h62, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("setwins_blocked", iss0_valid, 0);
    check("setwins_in_ready", in_ready, 0);
    wb(4'd3);
    wait_drain(10);

    // Reset while slot1 sits in HOLD_YOUNG with a stalled lane0 group.
    @(posedge clk); #1 iss_ready = 1'b0;
    send(4'd9, 4'd2, 4'd2, 8'h71, 1'b1, 4'd10, 4'd9, 4'd2, 8'h72);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", iss0_valid, 1);
    check("pre_rst_op", iss0_op, 8'h71);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_v0", iss0_valid, 0);
    check("midrst_v1", iss1_valid, 0);
    check("midrst_op0", iss0_op, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    iss_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    // Registers busy before reset must now be free.
    exp_q.push_back(g2(4'd9, 4'd10, 4'd6, 8'h81, 4'd12, 4'd13, 4'd14, 8'h82));
    send(4'd9, 4'd10, 4'd6, 8'h81, 1'b1, 4'd12, 4'd13, 4'd14, 8'h82);
    @(negedge clk);
    check("postrst_n1", iss0_valid, 0);
    @(negedge clk);
    check("postrst_n2", iss0_valid, 1);
    wait_drain(10);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
